lcd_show_char: RTL
==================

// Module: lcd_show_char
// PURPOSE
//  Draws one glyph on the SPI LCD. Sits between the string/number sequencer (upstream) and the
//  SPI byte writer (downstream). On show_char_flag it captures char index/position/size, emits the
//  column/row window and RAMWR command bytes, then streams RGB565 pixels from a font ROM.
//  It pulses show_char_done when the glyph is complete.
// PARAMETERS
//  LCD_W     240      panel width in pixels; glyph must satisfy start_x+W <= LCD_W
//  LCD_H     320      panel height in pixels; glyph must satisfy start_y+H <= LCD_H
//  FG_COLOR  16'h0000 RGB565 colour for set font bits
//  BG_COLOR  16'hFFFF RGB565 colour for clear font bits
// PORTS
//  sys_clk         in   1  system clock
//  sys_rst         in   1  reset; asynchronous, active-high (one clock, no other clock domains)
//  show_char_flag  in   1  1-cycle start pulse; ignored while busy
//  ascii_num       in   7  font index = ASCII-32 (0..94); values >94 draw blank (BG only)
//  start_x         in   9  left pixel column of glyph
//  start_y         in   9  top pixel row of glyph
//  en_size         in   1  1: 16x8 font (W=8,H=16); 0: 12x6 font (W=6,H=12)
//  wr_en           out  1  1-cycle request to SPI writer; wr_data valid from wr_en until wr_done
//  wr_data         out  9  [8]=D/C (0 cmd, 1 data), [7:0] byte
//  wr_done         in   1  1-cycle pulse from SPI writer: current byte shifted out
//  show_char_done  out  1  1-cycle pulse: glyph finished or request rejected
//  busy            out  1  high from accepted flag until the cycle show_char_done pulses
// BEHAVIOUR
//  - Reset: state IDLE; wr_en=0, wr_data=0, show_char_done=0, busy=0; counters cleared.
//  - IDLE: on show_char_flag, register ascii_num/start_x/start_y/en_size; busy=1 next cycle.
//    If start_x+W>LCD_W or start_y+H>LCD_H -> REJECT: no writes, show_char_done next cycle.
//  - WIN: 11 bytes in order: {0,2A},{1,xs[15:8]},{1,xs[7:0]},{1,xe hi},{1,xe lo},
//    {0,2B},{1,ys hi},{1,ys lo},{1,ye hi},{1,ye lo},{0,2C}; xe=start_x+W-1, ye=start_y+H-1,
//    zero-extended to 16 bits. First wr_en 1 cycle after flag accepted.
//  - Exactly one byte outstanding: next wr_en no earlier than 1 cycle after wr_done.
//  - FETCH: present {size,char,row} to ROM; 1-cycle ROM latency; latch row_bits[7:0].
//  - PIX: for col 0..W-1: pixel = row_bits[7-col] ? FG : BG; send hi byte then lo byte (D/C=1).
//    After col W-1, row++ -> FETCH; after row H-1 last lo-byte wr_done -> DONE.
//  - DONE: show_char_done=1 for 1 cycle, busy=0 same cycle, -> IDLE. Accepts new flag next cycle.
//  - Byte counts: 12x6 -> 11+144=155 bytes; 16x8 -> 11+256=267 bytes.
//  - Flag while busy (incl. DONE cycle): dropped, no effect on current glyph.
//  - wr_done while no request outstanding: ignored.
//  - Input changes after capture: no effect on the glyph in flight.
//  - Reset mid-glyph: immediate abort to IDLE, wr_en low, no show_char_done.
//  - Counters: col 3b, row 4b, byte-in-window 4b; no wrap beyond terminal values.
// STRUCTURE
//  - Shared package lcd_pkg: LCD cmd constants (CASET 8'h2A, RASET 8'h2B, RAMWR 8'h2C),
//    font dims (W/H per size), state enum {IDLE,WIN,FETCH,PIX,DONE,REJECT}.
//  - Sub-module char_font_rom(sys_clk, size, char_idx[6:0], row[3:0] -> row_bits[7:0]):
//    registered read, 95x16 rows (16x8) + 95x12 rows (12x6, bits[7:2] used, [1:0]=0);
//    index >94 or row>=H returns 0.
//  - Top: FSM + counters + byte mux; SPI writer is external.
// TESTING
//  - Bench SPI model answers wr_done 3 cycles after each wr_en; it logs all bytes.
//  - en_size=0, ascii_num=82, (8,48): 155 bytes; window 0008..000D, 0030..003B.
//    Pixels match ROM for index 82; exactly one done pulse.
//  - en_size=1, ascii_num=33, (72,16): 267 bytes; first 11 = 2A,00,48,00,4F,2B,00,10,00,1F,2C.
//  - ascii_num=0 (space), 12x6: all 72 pixels = BG_COLOR bytes FF,FF.
//    ascii_num=120 -> also all BG.
//  - start_x=236, en_size=1 (LCD_W=240): zero wr_en; done 1 cycle after flag.
//  - Extra flag mid-glyph plus spurious wr_done while idle: byte stream unchanged, single done.
//  - sys_rst asserted after byte 50: wr_en=0 at once, no done.
//    New flag after release restarts cleanly from byte 2A.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD glyph drawer: controller command bytes,
// per-size glyph geometry and the drawing state machine encoding.
package lcd_pkg;

    localparam logic [7:0] CASET = 8'h2A;
    localparam logic [7:0] RASET = 8'h2B;
    localparam logic [7:0] RAMWR = 8'h2C;

    localparam logic [6:0] MAX_CHAR_IDX = 7'd94;
    localparam logic [3:0] WIN_LAST_BYTE = 4'd10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WIN    = 3'd1,
        FETCH  = 3'd2,
        PIX    = 3'd3,
        DONE   = 3'd4,
        REJECT = 3'd5
    } state_t;

    // size=1 selects the 16x8 font, size=0 the 12x6 font.
    function automatic logic [3:0] glyph_w(input logic size);
        return size ? 4'd8 : 4'd6;
    endfunction

    function automatic logic [4:0] glyph_h(input logic size);
        return size ? 5'd16 : 5'd12;
    endfunction

    function automatic logic [2:0] glyph_last_col(input logic size);
        return size ? 3'd7 : 3'd5;
    endfunction

    function automatic logic [3:0] glyph_last_row(input logic size);
        return size ? 4'd15 : 4'd11;
    endfunction

endpackage

// File: rtl/char_font_rom.sv
// Registered glyph-row lookup for both font sizes. One cycle from address to
// row_bits; MSB is the leftmost pixel, 12x6 rows only use bits [7:2].
module char_font_rom
    import lcd_pkg::*;
(
    input  logic       sys_clk,
    input  logic       size,
    input  logic [6:0] char_idx,
    input  logic [3:0] row,
    output logic [7:0] row_bits
);

    logic [7:0] raw;
    logic [7:0] row_bits_d;
    logic [7:0] row_bits_q;

    // Glyph patterns come from a fixed arithmetic hash of (index,row,size) so the
    // table stays compact; index 0 (space) and out-of-range addresses are blank.
    always_comb begin
        raw = ({1'b0, char_idx} * 8'd29) + ({4'b0000, row} * 8'd53) + (size ? 8'd101 : 8'd0);
        row_bits_d = 8'h00;
        if ((char_idx != 7'd0) && (char_idx <= MAX_CHAR_IDX) && ({1'b0, row} < glyph_h(size))) begin
            row_bits_d = size ? raw : (raw & 8'hFC);
        end
    end

    always_ff @(posedge sys_clk) begin
        row_bits_q <= row_bits_d;
    end

    assign row_bits = row_bits_q;

endmodule

// File: rtl/lcd_show_char.sv
// Draws one glyph: sends the CASET/RASET/RAMWR window bytes, then streams
// RGB565 pixels row by row from the font ROM, one SPI byte in flight at a time.
module lcd_show_char
    import lcd_pkg::*;
#(
    parameter int unsigned LCD_W    = 240,
    parameter int unsigned LCD_H    = 320,
    parameter logic [15:0] FG_COLOR = 16'h0000,
    parameter logic [15:0] BG_COLOR = 16'hFFFF
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       show_char_flag,
    input  logic [6:0] ascii_num,
    input  logic [8:0] start_x,
    input  logic [8:0] start_y,
    input  logic       en_size,
    output logic       wr_en,
    output logic [8:0] wr_data,
    input  logic       wr_done,
    output logic       show_char_done,
    output logic       busy,
    output state_t     dbg_state
);

    localparam logic [9:0] LCD_W_L = 10'(LCD_W);
    localparam logic [9:0] LCD_H_L = 10'(LCD_H);

    state_t     state_q, state_d;
    logic [6:0] char_q, char_d;
    logic [8:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic       size_q, size_d;
    logic [3:0] byte_q, byte_d;
    logic [3:0] row_q, row_d;
    logic [2:0] col_q, col_d;
    logic       lo_q, lo_d;
    logic       pend_q, pend_d;
    logic       fetch_wait_q, fetch_wait_d;
    logic [7:0] row_bits_q, row_bits_d;

    logic [7:0]  rom_bits;
    logic [9:0]  end_x_in;
    logic [9:0]  end_y_in;
    logic        out_of_bounds;
    logic [15:0] xs16, xe16, ys16, ye16;
    logic [8:0]  win_word;
    logic [15:0] pixel;

    char_font_rom u_rom (
        .sys_clk  (sys_clk),
        .size     (size_q),
        .char_idx (char_q),
        .row      (row_q),
        .row_bits (rom_bits)
    );

    // Bounds are judged on the live inputs so a reject answers in one cycle.
    always_comb begin
        end_x_in      = {1'b0, start_x} + {6'b000000, glyph_w(en_size)};
        end_y_in      = {1'b0, start_y} + {5'b00000, glyph_h(en_size)};
        out_of_bounds = (end_x_in > LCD_W_L) || (end_y_in > LCD_H_L);
    end

    always_comb begin
        xs16 = {7'b0000000, x_q};
        xe16 = xs16 + {12'h000, glyph_w(size_q)} - 16'd1;
        ys16 = {7'b0000000, y_q};
        ye16 = ys16 + {11'b00000000000, glyph_h(size_q)} - 16'd1;
        case (byte_q)
            4'd0:    win_word = {1'b0, CASET};
            4'd1:    win_word = {1'b1, xs16[15:8]};
            4'd2:    win_word = {1'b1, xs16[7:0]};
            4'd3:    win_word = {1'b1, xe16[15:8]};
            4'd4:    win_word = {1'b1, xe16[7:0]};
            4'd5:    win_word = {1'b0, RASET};
            4'd6:    win_word = {1'b1, ys16[15:8]};
            4'd7:    win_word = {1'b1, ys16[7:0]};
            4'd8:    win_word = {1'b1, ye16[15:8]};
            4'd9:    win_word = {1'b1, ye16[7:0]};
            4'd10:   win_word = {1'b0, RAMWR};
            default: win_word = 9'h000;
        endcase
        pixel = row_bits_q[3'd7 - col_q] ? FG_COLOR : BG_COLOR;
    end

    // wr_data is decoded from registered counters, so it holds steady from the
    // request until wr_done advances them.
    always_comb begin
        state_d        = state_q;
        char_d         = char_q;
        x_d            = x_q;
        y_d            = y_q;
        size_d         = size_q;
        byte_d         = byte_q;
        row_d          = row_q;
        col_d          = col_q;
        lo_d           = lo_q;
        pend_d         = pend_q;
        fetch_wait_d   = fetch_wait_q;
        row_bits_d     = row_bits_q;
        wr_en          = 1'b0;
        wr_data        = 9'h000;
        show_char_done = 1'b0;
        busy           = 1'b0;

        case (state_q)
            IDLE: begin
                if (show_char_flag) begin
                    char_d       = ascii_num;
                    x_d          = start_x;
                    y_d          = start_y;
                    size_d       = en_size;
                    byte_d       = 4'd0;
                    row_d        = 4'd0;
                    col_d        = 3'd0;
                    lo_d         = 1'b0;
                    pend_d       = 1'b0;
                    fetch_wait_d = 1'b0;
                    state_d      = out_of_bounds ? REJECT : WIN;
                end
            end

            WIN: begin
                busy    = 1'b1;
                wr_data = win_word;
                if (!pend_q) begin
                    wr_en  = 1'b1;
                    pend_d = 1'b1;
                end else if (wr_done) begin
                    pend_d = 1'b0;
                    if (byte_q == WIN_LAST_BYTE) begin
                        state_d = FETCH;
                    end else begin
                        byte_d = byte_q + 4'd1;
                    end
                end
            end

            FETCH: begin
                busy = 1'b1;
                if (!fetch_wait_q) begin
                    fetch_wait_d = 1'b1;
                end else begin
                    fetch_wait_d = 1'b0;
                    row_bits_d   = rom_bits;
                    col_d        = 3'd0;
                    lo_d         = 1'b0;
                    state_d      = PIX;
                end
            end

            PIX: begin
                busy    = 1'b1;
                wr_data = {1'b1, lo_q ? pixel[7:0] : pixel[15:8]};
                if (!pend_q) begin
                    wr_en  = 1'b1;
                    pend_d = 1'b1;
                end else if (wr_done) begin
                    pend_d = 1'b0;
                    if (!lo_q) begin
                        lo_d = 1'b1;
                    end else begin
                        lo_d = 1'b0;
                        if (col_q == glyph_last_col(size_q)) begin
                            col_d = 3'd0;
                            if (row_q == glyph_last_row(size_q)) begin
                                state_d = DONE;
                            end else begin
                                row_d   = row_q + 4'd1;
                                state_d = FETCH;
                            end
                        end else begin
                            col_d = col_q + 3'd1;
                        end
                    end
                end
            end

            DONE, REJECT: begin
                show_char_done = 1'b1;
                state_d        = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            char_q       <= 7'd0;
            x_q          <= 9'd0;
            y_q          <= 9'd0;
            size_q       <= 1'b0;
            byte_q       <= 4'd0;
            row_q        <= 4'd0;
            col_q        <= 3'd0;
            lo_q         <= 1'b0;
            pend_q       <= 1'b0;
            fetch_wait_q <= 1'b0;
            row_bits_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            char_q       <= char_d;
            x_q          <= x_d;
            y_q          <= y_d;
            size_q       <= size_d;
            byte_q       <= byte_d;
            row_q        <= row_d;
            col_q        <= col_d;
            lo_q         <= lo_d;
            pend_q       <= pend_d;
            fetch_wait_q <= fetch_wait_d;
            row_bits_q   <= row_bits_d;
        end
    end

    assign dbg_state = state_q;

endmodule
